// File: rtl/alu_multicycle_if.sv
// Start/busy/done handshake bundle between the EX stage and the multi-cycle ALU.
interface alu_multicycle_if #(
  parameter int unsigned N = 64
);
  logic         start;
  logic [3:0]   alucontrol;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic         zero;

  modport master (
    output start, alucontrol, a, b,
    input  busy, done, result, zero
  );

  modport slave (
    input  start, alucontrol, a, b,
    output busy, done, result, zero
  );
endinterface

// File: rtl/alu_multicycle.sv
// Execute unit: single-cycle logic/arith codes plus an N-cycle shift-add multiplier.
module alu_multicycle #(
  parameter int unsigned N = 64
) (
  input logic              clk,
  input logic              reset,
  alu_multicycle_if.slave  bus
);
  localparam int unsigned CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [0:0] {IDLE, MUL} state_t;

  state_t        state, state_next;
  logic [N-1:0]  mcand, mcand_next;
  logic [N-1:0]  mplier, mplier_next;
  logic [N-1:0]  acc, acc_next;
  logic [CW-1:0] count, count_next;
  logic [N-1:0]  result, result_next;
  logic          zero, zero_next;
  logic          done, done_next;
  logic [N-1:0]  alu_out;
  logic [N-1:0]  acc_sum;

  always_comb begin
    alu_out = '0;
    case (bus.alucontrol)
      4'b0000: alu_out = bus.a & bus.b;
      4'b0001: alu_out = bus.a | bus.b;
      4'b0010: alu_out = bus.a + bus.b;
      4'b0110: alu_out = bus.a - bus.b;
      4'b0111: alu_out = bus.b;
      default: alu_out = '0;
    endcase
  end

  assign acc_sum = mplier[0] ? acc + mcand : acc;

  always_comb begin
    state_next  = state;
    mcand_next  = mcand;
    mplier_next = mplier;
    acc_next    = acc;
    count_next  = count;
    result_next = result;
    zero_next   = zero;
    done_next   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.alucontrol == 4'b1000) begin
            mcand_next  = bus.a;
            mplier_next = bus.b;
            acc_next    = '0;
            count_next  = '0;
            state_next  = MUL;
          end else begin
            result_next = alu_out;
            zero_next   = (alu_out == '0);
            done_next   = 1'b1;
          end
        end
      end
      MUL: begin
        acc_next    = acc_sum;
        mcand_next  = mcand << 1;
        mplier_next = mplier >> 1;
        count_next  = count + 1'b1;
        // Final iteration publishes the partial sum formed on this same edge.
        if (count == LAST) begin
          result_next = acc_sum;
          zero_next   = (acc_sum == '0);
          done_next   = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
      result <= '0;
      zero   <= 1'b1;
      done   <= 1'b0;
    end else begin
      state  <= state_next;
      mcand  <= mcand_next;
      mplier <= mplier_next;
      acc    <= acc_next;
      count  <= count_next;
      result <= result_next;
      zero   <= zero_next;
      done   <= done_next;
    end
  end

  assign bus.busy   = (state == MUL);
  assign bus.done   = done;
  assign bus.result = result;
  assign bus.zero   = zero;
endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Multi-cycle execute unit; consumes the 4-bit ALU control code produced by the ALU control decoder.
- Adds an iterative shift-add multiplier alongside the existing single-cycle ALU codes.
- Sits in EX behind a start/busy/done handshake. The pipeline stalls on busy and captures result on done.

Parameters:
N, 64, operand/result width in bits (≥2; iteration counter sized ceil(log2 N)+1)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high
start  input  1  request; sampled only when busy=0
alucontrol  input  4  operation code
a  input  N  operand A
b  input  N  operand B
busy  output  1  high while a multiply is in progress
done  output  1  one-cycle pulse: result/zero just updated
result  output  N  registered result, held until next completion
zero  output  1  registered (result==0), updated with result

Behaviour:
- Reset, sampled at an edge: state=IDLE, busy=0, done=0, result=0, zero=1, internal accumulator/counter cleared. Reset overrides everything, including mid-multiply: the operation aborts with no done pulse.
- Op codes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB (a−b)
  - 0111 pass b (CBZ)
  - 1000 MUL: low N bits of unsigned a×b
  - Any other code: result 0.
- ADD/SUB/MUL wrap modulo 2^N. No flags other than zero.
- States: IDLE, MUL.
- IDLE, start=1, code≠1000: result and zero updated at that edge; done=1 for the following cycle. Latency 1. State stays IDLE, busy stays 0.
- IDLE, start=1, code=1000:
  - At that edge (E0): latch a→multiplicand, b→multiplier; acc=0, count=0; state=MUL, busy=1, done=0.
- MUL, each edge:
  - If multiplier[0], acc += multiplicand.
  - multiplicand <<= 1; multiplier >>= 1; count++.
  - The edge performing iteration count==N−1 (edge E_N) writes the final acc to result, updates zero, and sets done=1, busy=0, state=IDLE.
  - Latency: N cycles. busy is high for exactly N cycles.
  - No early termination.
- Operands and alucontrol are latched at start. Changes during busy have no effect.
- start while busy=1 is ignored. No queueing, no error.
- done is deasserted the cycle after it rises unless a new single-cycle op completes at that edge.
- start is accepted in the cycle done=1 (state already IDLE). This gives back-to-back operation.
- result/zero change only on completion or reset.
- start=0 in IDLE: nothing changes; done=0.

Test Plan:
- ADD wrap: reset, then start with code 0010, a=all-ones, b=1 → cycle after: done=1, result=0, zero=1, busy never high; done=0 next cycle.
- SUB/logic: SUB a=5, b=7 → result=2^N−2, zero=0. AND a=0xF0F0, b=0xFF00 → 0xF000. OR same operands → 0xFFF0. Code 0111, b=0 → zero=1. Code 1111 → result 0, done pulse.
- MUL timing: code 1000, a=3, b=5 → busy=1 for exactly 64 cycles; done=1 once, in the cycle after E64; result=15. At start, change a/b/alucontrol the next cycle and pulse start mid-busy → result still 15, no extra done.
- MUL overflow: a=2^63, b=2 → result=0, zero=1. a=all-ones, b=all-ones → result=1.
- Reset mid-multiply: assert reset for one edge at busy cycle 10 → busy=0, done=0, result=0, zero=1, with no later done. A following ADD 2+3 gives result=5 one cycle after start.
- Back-to-back: assert start with ADD 1+1 in the same cycle the MUL done=1 → next cycle done=1 again, result=2.
